// File: rtl/des_block_serializer.sv
// Block-to-byte serializer: buffers 64-bit ciphertext blocks in a small circular
// buffer and emits each block as eight bytes, MSB first, over a valid/ready link.
module des_block_serializer #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] blk_in,
  input  logic        blk_valid,
  output logic        blk_ready,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        byte_last,
  output logic        busy
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [PW-1:0] PtrMax = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CntMax = CW'(DEPTH);

  logic [63:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [2:0]    idx;

  logic          push;
  logic          byte_hs;
  logic          pop;
  logic [63:0]   head;
  logic [63:0]   head_shifted;

  // Ready comes from registered occupancy only; rst forces it low while asserted.
  assign blk_ready  = ~rst & (count < CntMax);
  assign byte_valid = (count != '0);
  assign busy       = (count != '0);
  assign byte_last  = byte_valid & (idx == 3'd7);

  assign push    = blk_valid & blk_ready;
  assign byte_hs = byte_valid & byte_ready;
  assign pop     = byte_hs & (idx == 3'd7);

  // Select the current byte of the head block, MSB first; zero when idle.
  always_comb begin
    head         = mem[rd_ptr];
    head_shifted = head << {idx, 3'b000};
    byte_out     = byte_valid ? head_shifted[63:56] : 8'h00;
  end

  // Block storage; only written on an accepted push, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= blk_in;
    end
  end

  // Pointers, occupancy and byte index of the head block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      idx    <= 3'd0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PtrMax) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PtrMax) ? '0 : rd_ptr + 1'b1;
      end
      if (byte_hs) begin
        idx <= idx + 3'd1;  // wraps 7 -> 0 at the block boundary
      end
      // Simultaneous push and final-byte pop leave occupancy unchanged.
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_des_block_serializer.sv
// Self-checking bench for des_block_serializer: a queue-of-blocks reference model
// predicts every output each cycle; scenario tasks add targeted checks.
module tb_des_block_serializer;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] blk_in;
  logic        blk_valid;
  logic        blk_ready;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic        byte_last;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: queued blocks and the position within the head block.
  logic [63:0] mq[$];
  int          midx;

  des_block_serializer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .blk_in     (blk_in),
    .blk_valid  (blk_valid),
    .blk_ready  (blk_ready),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_last  (byte_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [7:0] exp_byte();
    logic [63:0] h;
    if (mq.size() == 0) return 8'h00;
    h = mq[0];
    return 8'((h >> (56 - 8 * midx)) & 64'hFF);
  endfunction

  // {blk_ready, byte_valid, byte_last, busy, byte_out}
  function automatic logic [11:0] exp_outs();
    logic v;
    v = (mq.size() != 0);
    return {(mq.size() < DEPTH), v, v && (midx == 7), v, exp_byte()};
  endfunction

  function automatic logic [11:0] got_outs();
    return {blk_ready, byte_valid, byte_last, busy, byte_out};
  endfunction

  // Clock one edge, applying the transfer rules to the model; returns whether a push occurred.
  task automatic advance(output bit pushed);
    bit push, pop;
    push = blk_valid && (mq.size() < DEPTH) && !rst;
    pop  = (mq.size() != 0) && byte_ready;
    @(posedge clk);
    if (pop) begin
      if (midx == 7) begin
        void'(mq.pop_front());
        midx = 0;
      end else begin
        midx++;
      end
    end
    if (push) mq.push_back(blk_in);
    pushed = push;
    #1;
  endtask

  task automatic test_reset();
    bit p;
    rst = 1'b1; blk_valid = 1'b0; byte_ready = 1'b0; blk_in = '0;
    mq.delete(); midx = 0;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (got_outs() !== 12'h000) begin
      mismatched++;
      $display("FAIL reset_held: got %h want %h", got_outs(), 12'h000);
    end
    rst = 1'b0;
    #1;
    compared++;
    if (got_outs() !== 12'h800) begin
      mismatched++;
      $display("FAIL reset_release: got %h want %h", got_outs(), 12'h800);
    end
    advance(p);
  endtask

  task automatic test_single();
    logic [7:0] want [8] = '{8'h85, 8'hE8, 8'h13, 8'h54, 8'h0F, 8'h0A, 8'hB4, 8'h05};
    bit p;
    blk_in = 64'h85E813540F0AB405; blk_valid = 1'b1; byte_ready = 1'b1;
    advance(p);
    blk_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      compared++;
      if (got_outs() !== exp_outs() || byte_out !== want[i] || byte_last !== (i == 7)) begin
        mismatched++;
        $display("FAIL single byte %0d: got %h want %h (byte %h)", i, got_outs(), exp_outs(),
                 want[i]);
      end
      advance(p);
    end
    compared++;
    if (busy !== 1'b0 || byte_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL single_idle: got busy=%b valid=%b want 0 0", busy, byte_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] seen[$];
    logic [63:0] blk;
    logic [63:0] cat;
    bit p;
    blk = rand64();
    blk_in = blk; blk_valid = 1'b1; byte_ready = 1'b0;
    advance(p);
    blk_valid = 1'b0;
    for (int c = 0; c < 16; c++) begin
      byte_ready = (c % 2 == 0);
      compared++;
      if (got_outs() !== exp_outs()) begin
        mismatched++;
        $display("FAIL backpressure cyc %0d: got %h want %h", c, got_outs(), exp_outs());
      end
      if (byte_valid && byte_ready) seen.push_back(byte_out);
      advance(p);
    end
    cat = '0;
    foreach (seen[i]) cat = (cat << 8) | 64'(seen[i]);
    compared++;
    if (seen.size() != 8 || cat !== blk) begin
      mismatched++;
      $display("FAIL backpressure_seq: got %0d bytes %h want 8 bytes %h", seen.size(), cat, blk);
    end
  endtask

  task automatic test_fill();
    logic [63:0] blks [3];
    int c_cycle, last_cycle;
    bit p;
    for (int i = 0; i < 3; i++) blks[i] = rand64();
    byte_ready = 1'b0; blk_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      blk_in = blks[i];
      advance(p);
      compared++;
      if (p !== 1'b1) begin
        mismatched++;
        $display("FAIL fill_accept %0d: got %b want 1", i, p);
      end
    end
    blk_in = blks[2];
    compared++;
    if (blk_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL fill_full: got blk_ready=%b want 0", blk_ready);
    end
    byte_ready = 1'b1;
    c_cycle = -1; last_cycle = -1;
    for (int c = 0; c < 20 && c_cycle < 0; c++) begin
      compared++;
      if (got_outs() !== exp_outs()) begin
        mismatched++;
        $display("FAIL fill cyc %0d: got %h want %h", c, got_outs(), exp_outs());
      end
      if (byte_last && last_cycle < 0) last_cycle = c;
      advance(p);
      if (p) begin
        c_cycle = c;
        blk_valid = 1'b0;
      end
    end
    compared++;
    if (last_cycle < 0 || c_cycle != last_cycle + 1) begin
      mismatched++;
      $display("FAIL fill_c_timing: got accept cycle %0d want %0d", c_cycle, last_cycle + 1);
    end
    for (int c = 0; c < 20; c++) begin
      compared++;
      if (got_outs() !== exp_outs()) begin
        mismatched++;
        $display("FAIL fill_drain cyc %0d: got %h want %h", c, got_outs(), exp_outs());
      end
      advance(p);
    end
  endtask

  task automatic test_stream();
    logic [63:0] blks [5];
    int n_push, n_bytes, run, max_run;
    bit p;
    for (int i = 0; i < 5; i++) blks[i] = rand64();
    n_push = 0; n_bytes = 0; run = 0; max_run = 0;
    byte_ready = 1'b1; blk_valid = 1'b1; blk_in = blks[0];
    for (int c = 0; c < 50; c++) begin
      compared++;
      if (got_outs() !== exp_outs()) begin
        mismatched++;
        $display("FAIL stream cyc %0d: got %h want %h", c, got_outs(), exp_outs());
      end
      if (byte_valid) begin
        n_bytes++; run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      advance(p);
      if (p) begin
        n_push++;
        if (n_push < 5) blk_in = blks[n_push];
        else blk_valid = 1'b0;
      end
    end
    compared++;
    if (n_bytes != 40 || max_run != 40) begin
      mismatched++;
      $display("FAIL stream_continuity: got %0d bytes run %0d want 40 run 40", n_bytes, max_run);
    end
  endtask

  task automatic test_simultaneous();
    logic [63:0] x, y;
    bit p;
    x = rand64(); y = rand64();
    blk_in = x; blk_valid = 1'b1; byte_ready = 1'b0;
    advance(p);
    blk_valid = 1'b0; byte_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      compared++;
      if (got_outs() !== exp_outs()) begin
        mismatched++;
        $display("FAIL simul byte %0d: got %h want %h", i, got_outs(), exp_outs());
      end
      advance(p);
    end
    blk_in = y; blk_valid = 1'b1;
    compared++;
    if (byte_last !== 1'b1 || byte_out !== x[7:0]) begin
      mismatched++;
      $display("FAIL simul_last: got last=%b byte=%h want 1 %h", byte_last, byte_out, x[7:0]);
    end
    advance(p);
    blk_valid = 1'b0;
    compared++;
    if (p !== 1'b1 || byte_out !== y[63:56] || busy !== 1'b1 || blk_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL simul_next: got byte=%h busy=%b ready=%b want %h 1 1", byte_out, busy,
               blk_ready, y[63:56]);
    end
    for (int i = 0; i < 9; i++) advance(p);
    compared++;
    if (got_outs() !== exp_outs()) begin
      mismatched++;
      $display("FAIL simul_drain: got %h want %h", got_outs(), exp_outs());
    end
  endtask

  task automatic test_reset_mid();
    bit p;
    blk_in = 64'h0123456789ABCDEF; blk_valid = 1'b1; byte_ready = 1'b0;
    advance(p);
    blk_valid = 1'b0; byte_ready = 1'b1;
    for (int i = 0; i < 4; i++) advance(p);
    compared++;
    if (byte_out !== 8'h89) begin
      mismatched++;
      $display("FAIL reset_mid_pre: got %h want 89", byte_out);
    end
    #2 rst = 1'b1;
    #1;
    mq.delete(); midx = 0;
    compared++;
    if (got_outs() !== 12'h000) begin
      mismatched++;
      $display("FAIL reset_mid_async: got %h want %h", got_outs(), 12'h000);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    blk_in = 64'hFEDCBA9876543210; blk_valid = 1'b1; byte_ready = 1'b0;
    advance(p);
    blk_valid = 1'b0;
    compared++;
    if (byte_out !== 8'hFE || byte_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_mid_first: got %h valid=%b want FE 1", byte_out, byte_valid);
    end
    byte_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      compared++;
      if (got_outs() !== exp_outs()) begin
        mismatched++;
        $display("FAIL reset_mid cyc %0d: got %h want %h", i, got_outs(), exp_outs());
      end
      advance(p);
    end
  endtask

  task automatic test_random();
    bit p;
    for (int c = 0; c < 400; c++) begin
      if (!blk_valid || p) blk_in = rand64();
      blk_valid  = ($urandom_range(0, 2) != 0);
      byte_ready = ($urandom_range(0, 3) != 0);
      compared++;
      if (got_outs() !== exp_outs()) begin
        mismatched++;
        $display("FAIL random cyc %0d: got %h want %h", c, got_outs(), exp_outs());
      end
      advance(p);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_fill();
    test_stream();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
